// File: rtl/scan_code_decoder_pkg.sv
// Shared state encoding and PS/2 set-2 byte constants for the scan code decoder.
package scan_code_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0,
    SKIP_PAUSE
  } stateT;

  localparam logic [7:0] CODE_E0     = 8'hE0;
  localparam logic [7:0] CODE_F0     = 8'hF0;
  localparam logic [7:0] CODE_E1     = 8'hE1;
  localparam logic [7:0] CODE_AA     = 8'hAA;
  localparam logic [7:0] CODE_FA     = 8'hFA;
  localparam logic [7:0] CODE_FE     = 8'hFE;
  localparam logic [7:0] CODE_EE     = 8'hEE;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

endpackage

// File: rtl/scan_code_decoder_if.sv
// Byte strobe from the PS/2 receiver plus the decoded key-event bundle.
interface scan_code_decoder_if;
  logic       NewScanCode;
  logic [7:0] ScanCode;
  logic       KeyEvent;
  logic [7:0] KeyCode;
  logic       Extended;
  logic       Released;
  logic [7:0] Ascii;
  logic       AsciiValid;
  logic       ShiftState;
  logic       CapsLock;
  logic       SeqError;

  modport master (
    output NewScanCode, ScanCode,
    input  KeyEvent, KeyCode, Extended, Released, Ascii, AsciiValid,
           ShiftState, CapsLock, SeqError
  );

  modport slave (
    input  NewScanCode, ScanCode,
    output KeyEvent, KeyCode, Extended, Released, Ascii, AsciiValid,
           ShiftState, CapsLock, SeqError
  );
endinterface

// File: rtl/scan_code_decoder_to_ascii.sv
// Combinational US-layout translation of a set-2 key code; the caller masks breaks.
module scan_to_ascii (
  input  logic [7:0] KeyCode,
  input  logic       Extended,
  input  logic       Shift,
  input  logic       Caps,
  output logic [7:0] Ascii,
  output logic       AsciiValid
);
  logic [7:0] lower;
  logic [7:0] plain;
  logic [7:0] shifted;

  always_comb begin
    lower   = 8'h00;
    plain   = 8'h00;
    shifted = 8'h00;
    case (KeyCode)
      8'h1C: lower = "a";
      8'h32: lower = "b";
      8'h21: lower = "c";
      8'h23: lower = "d";
      8'h24: lower = "e";
      8'h2B: lower = "f";
      8'h34: lower = "g";
      8'h33: lower = "h";
      8'h43: lower = "i";
      8'h3B: lower = "j";
      8'h42: lower = "k";
      8'h4B: lower = "l";
      8'h3A: lower = "m";
      8'h31: lower = "n";
      8'h44: lower = "o";
      8'h4D: lower = "p";
      8'h15: lower = "q";
      8'h2D: lower = "r";
      8'h1B: lower = "s";
      8'h2C: lower = "t";
      8'h3C: lower = "u";
      8'h2A: lower = "v";
      8'h1D: lower = "w";
      8'h22: lower = "x";
      8'h35: lower = "y";
      8'h1A: lower = "z";
      8'h45: begin plain = "0"; shifted = ")"; end
      8'h16: begin plain = "1"; shifted = "!"; end
      8'h1E: begin plain = "2"; shifted = "@"; end
      8'h26: begin plain = "3"; shifted = "#"; end
      8'h25: begin plain = "4"; shifted = "$"; end
      8'h2E: begin plain = "5"; shifted = "%"; end
      8'h36: begin plain = "6"; shifted = "^"; end
      8'h3D: begin plain = "7"; shifted = "&"; end
      8'h3E: begin plain = "8"; shifted = "*"; end
      8'h46: begin plain = "9"; shifted = "("; end
      8'h29: begin plain = 8'h20; shifted = 8'h20; end
      8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
      8'h66: begin plain = 8'h08; shifted = 8'h08; end
      8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
      default: ;
    endcase

    Ascii      = 8'h00;
    AsciiValid = 1'b0;
    if (Extended) begin
      // keypad Enter is the only extended key with a character
      if (KeyCode == 8'h5A) begin
        Ascii      = 8'h0D;
        AsciiValid = 1'b1;
      end
    end else if (lower != 8'h00) begin
      Ascii      = (Shift ^ Caps) ? (lower - 8'h20) : lower;
      AsciiValid = 1'b1;
    end else if (plain != 8'h00) begin
      Ascii      = Shift ? shifted : plain;
      AsciiValid = 1'b1;
    end
  end
endmodule

// File: rtl/scan_code_decoder.sv
// PS/2 set-2 byte stream to key make/break events with shift/caps tracking.
//   state      | meaning
//   IDLE       | no prefix pending
//   GOT_E0     | extended prefix seen
//   GOT_F0     | break prefix seen
//   GOT_E0F0   | extended break prefix seen
//   SKIP_PAUSE | swallowing the rest of the 8-byte Pause sequence
module scan_code_decoder
  import scan_code_decoder_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 1_000_000
) (
  input logic                Clk,
  input logic                Reset,
  scan_code_decoder_if.slave bus
);
  localparam int TO_W = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

  stateT           state;
  logic [2:0]      skipCnt;
  logic [TO_W-1:0] toCnt;
  logic            lShiftHeld, rShiftHeld, capsHeld, capsLock;
  logic            keyEvent, extended, released, asciiValid, seqError;
  logic [7:0]      keyCode, ascii;
  logic            fire, fireExt, fireRel, firePause;
  logic [7:0]      rxByte, xlatAscii;
  logic            xlatValid, shiftState;

  assign rxByte     = bus.ScanCode;
  assign shiftState = lShiftHeld | rShiftHeld;

  // does the byte in this cycle complete a key event, and of what kind
  always_comb begin
    fire      = 1'b0;
    fireExt   = 1'b0;
    fireRel   = 1'b0;
    firePause = 1'b0;
    case (state)
      IDLE: fire = !(rxByte inside {CODE_E0, CODE_F0, CODE_E1, CODE_AA, CODE_FA,
                                    CODE_FE, CODE_EE, 8'h00, 8'hFF});
      GOT_E0: begin
        fire    = !(rxByte inside {CODE_F0, CODE_LSHIFT, CODE_E0});
        fireExt = 1'b1;
      end
      GOT_F0: begin
        fire    = !(rxByte inside {CODE_E0, CODE_F0});
        fireRel = 1'b1;
      end
      GOT_E0F0: begin
        fire    = !(rxByte inside {CODE_LSHIFT, CODE_E0, CODE_F0});
        fireExt = 1'b1;
        fireRel = 1'b1;
      end
      SKIP_PAUSE: begin
        fire      = (skipCnt <= 3'd1);
        firePause = 1'b1;
      end
      default: ;
    endcase
    fire = fire & bus.NewScanCode;
  end

  scan_to_ascii uXlat (
    .KeyCode    (rxByte),
    .Extended   (fireExt),
    .Shift      (shiftState),
    .Caps       (capsLock),
    .Ascii      (xlatAscii),
    .AsciiValid (xlatValid)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      skipCnt    <= '0;
      toCnt      <= '0;
      lShiftHeld <= 1'b0;
      rShiftHeld <= 1'b0;
      capsHeld   <= 1'b0;
      capsLock   <= 1'b0;
      keyEvent   <= 1'b0;
      keyCode    <= '0;
      extended   <= 1'b0;
      released   <= 1'b0;
      ascii      <= '0;
      asciiValid <= 1'b0;
      seqError   <= 1'b0;
    end else begin
      keyEvent <= 1'b0;
      seqError <= 1'b0;
      if (bus.NewScanCode) begin
        toCnt <= '0;
        case (state)
          IDLE: begin
            if (rxByte == CODE_E0) state <= GOT_E0;
            else if (rxByte == CODE_F0) state <= GOT_F0;
            else if (rxByte == CODE_E1) begin
              state   <= SKIP_PAUSE;
              skipCnt <= PAUSE_SKIP;
            end else if (rxByte == 8'h00 || rxByte == 8'hFF) seqError <= 1'b1;
          end
          GOT_E0: begin
            if (rxByte == CODE_F0) state <= GOT_E0F0;
            else if (rxByte == CODE_E0) seqError <= 1'b1;
            else state <= IDLE;
          end
          GOT_F0, GOT_E0F0: begin
            seqError <= (rxByte == CODE_E0) || (rxByte == CODE_F0);
            state    <= IDLE;
          end
          SKIP_PAUSE: begin
            skipCnt <= skipCnt - 3'd1;
            if (skipCnt <= 3'd1) begin
              state   <= IDLE;
              skipCnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase

        if (fire) begin
          keyEvent   <= 1'b1;
          keyCode    <= firePause ? CODE_E1 : rxByte;
          extended   <= fireExt;
          released   <= fireRel;
          ascii      <= (fireRel || firePause) ? 8'h00 : xlatAscii;
          asciiValid <= !fireRel && !firePause && xlatValid;
          if (!fireExt && !firePause) begin
            case (rxByte)
              CODE_LSHIFT: lShiftHeld <= !fireRel;
              CODE_RSHIFT: rShiftHeld <= !fireRel;
              CODE_CAPS: begin
                // typematic repeats arrive as makes while held; only the first toggles
                if (fireRel) capsHeld <= 1'b0;
                else begin
                  if (!capsHeld) capsLock <= !capsLock;
                  capsHeld <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end else if (state != IDLE) begin
        if (toCnt == TO_LAST) begin
          state    <= IDLE;
          skipCnt  <= '0;
          toCnt    <= '0;
          seqError <= 1'b1;
        end else begin
          toCnt <= toCnt + TO_W'(1);
        end
      end
    end
  end

  assign bus.KeyEvent   = keyEvent;
  assign bus.KeyCode    = keyCode;
  assign bus.Extended   = extended;
  assign bus.Released   = released;
  assign bus.Ascii      = ascii;
  assign bus.AsciiValid = asciiValid;
  assign bus.ShiftState = shiftState;
  assign bus.CapsLock   = capsLock;
  assign bus.SeqError   = seqError;
endmodule

// File: doc/scan_code_decoder.md
SCAN_CODE_DECODER -- requirements
Module: scan_code_decoder

Interface
REQ-001 Parameter PREFIX_TIMEOUT, default 1_000_000: Clk cycles a partial multi-byte sequence may wait before it is abandoned.
REQ-002 Clk  in  1  system clock; all state is updated on posedge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 NewScanCode  in  1  one-cycle strobe from the scan code receiver; ScanCode is valid in the same cycle.
REQ-005 ScanCode  in  8  received PS/2 byte.
REQ-006 KeyEvent  out  1  one-cycle pulse; one complete key make or break has been decoded.
REQ-007 KeyCode  out  8  final byte of the sequence, without E0/F0 prefixes; E1 marks Pause.
REQ-008 Extended  out  1  the sequence carried an E0 prefix.
REQ-009 Released  out  1  the sequence carried an F0 prefix (break).
REQ-010 Ascii  out  8  translated character for the event.
REQ-011 AsciiValid  out  1  Ascii is meaningful: make events only.
REQ-012 ShiftState  out  1  LShift OR RShift held.
REQ-013 CapsLock  out  1  caps lock toggle state.
REQ-014 SeqError  out  1  one-cycle pulse on an illegal sequence, an overrun byte or a timeout.

Function
REQ-015 FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_PAUSE; bytes are processed only in cycles where NewScanCode=1.
REQ-016 IDLE transitions:
- E0 -> GOT_E0.
- F0 -> GOT_F0.
- E1 -> SKIP_PAUSE with skip count 7.
- AA/FA/FE/EE -> ignored, stay in IDLE.
- 00/FF -> SeqError, stay in IDLE.
- Any other byte -> make event: Extended=0, Released=0.
REQ-017 GOT_E0 transitions:
- F0 -> GOT_E0F0.
- 12 -> discarded as a fake shift; go to IDLE with no event.
- E0 -> SeqError, stay in GOT_E0.
- Any other byte -> extended make event; go to IDLE.
REQ-018 GOT_F0:
- E0/F0 -> SeqError; go to IDLE.
- Any other byte -> break event (Released=1); go to IDLE.
REQ-019 GOT_E0F0:
- 12 -> discarded; go to IDLE.
- E0/F0 -> SeqError; go to IDLE.
- Any other byte -> extended break event; go to IDLE.
REQ-020 SKIP_PAUSE:
- Decrement the count on each byte.
- On the byte that brings the count to 0: emit KeyCode=E1, Extended=0, Released=0, AsciiValid=0; go to IDLE.
REQ-021 Latency: KeyEvent pulses in the cycle after the NewScanCode cycle that carried the final byte; the event fields are registered and update in that same cycle.
REQ-022 KeyCode, Extended, Released, Ascii and AsciiValid hold their values until the next KeyEvent.
REQ-023 Shift tracking: non-extended 12 (left) and 59 (right) set their held flag on make and clear it on break.
- These events still pulse KeyEvent.
- ShiftState updates in the same cycle as KeyEvent.
REQ-024 CapsLock: non-extended 58 make toggles CapsLock only when CapsHeld=0, then sets CapsHeld; 58 break clears CapsHeld, so typematic repeats do not re-toggle.
REQ-025 Ascii translation, make events only:
- a-z: uppercase when ShiftState XOR CapsLock, using the pre-event ShiftState.
- Digits 0-9: shifted symbols per the US layout when ShiftState=1.
- Space 29 -> 20; Enter 5A -> 0D; Backspace 66 -> 08; Esc 76 -> 1B.
- Extended E0 5A -> 0D.
- All other codes, all breaks and all other extended codes: AsciiValid=0, Ascii=00.
REQ-026 Timeout counter:
- Cleared on every NewScanCode; counts while the state is not IDLE.
- At PREFIX_TIMEOUT-1: go to IDLE, pulse SeqError, emit no KeyEvent.
REQ-027 If NewScanCode coincides with timeout expiry, the byte wins: it is processed in the current state and no SeqError is raised for the timeout.
REQ-028 KeyEvent and SeqError never pulse in the same cycle, except when an illegal byte also completes an event, which cannot occur by construction.

Reset
REQ-029 While Reset=0: state=IDLE; skip count=0; timeout counter=0; all held flags, CapsLock and every output = 0.
REQ-030 Reset asserted mid-sequence abandons the sequence; the first byte after release is decoded from IDLE.

Structure
REQ-031 The shared package holds:
- State encoding.
- Byte constants: E0, F0, E1, AA, FA, FE, EE, 12, 59, 58.
- PAUSE_SKIP=7.
REQ-032 One sub-module, scan_to_ascii: purely combinational; inputs KeyCode, Extended, Shift, Caps; outputs Ascii and AsciiValid; instantiated once.

Verification
REQ-033 Bytes 1C, F0 1C with Shift=0 and Caps=0:
- First event: KeyCode=1C, Released=0, Ascii=61, AsciiValid=1.
- Second event: Released=1, AsciiValid=0.
REQ-034 Bytes 12, 1C, F0 12, 58, 58, F0 58, 1C:
- First 1C: Ascii=41.
- CapsLock ends at 1 (single toggle).
- Final 1C: Ascii=41.
REQ-035 Bytes E0 75, E0 F0 75, E0 12, E0 F0 12:
- Two events: KeyCode=75 with Extended=1, the second with Released=1.
- Fake shift bytes produce no event and leave ShiftState=0.
REQ-036 Bytes E1 14 77 E1 F0 14 F0 77: exactly one KeyEvent, KeyCode=E1, after the 8th byte.
REQ-037 Byte E0, then no input for PREFIX_TIMEOUT cycles, then 1C:
- SeqError pulses once.
- 1C decodes as a non-extended make.
REQ-038 Reset:
- Reset=0 asserted between F0 and 1C: 1C then decodes as a make.
- Byte 00 in IDLE: pulses SeqError.
